// File: rtl/stopwatch_control_fsm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_control_fsm
//
// Front-panel controller for the 100 Hz stopwatch counter. Three raw push
// buttons pass through a 2-flop synchroniser and a debounce counter each.
// The debounced press pulses drive a Moore state machine that sequences the
// counter's run enable, freeze and clear. The block also captures lap times
// and selects between live and frozen time for the display.
//
// Ports:
//   CLK_100Hz      in   system clock, 100 Hz
//   reset_n        in   asynchronous active-low reset
//   btn_start_stop in   raw start/stop button, active high, asynchronous
//   btn_lap        in   raw lap button, active high, asynchronous
//   btn_clear      in   raw clear button, active high, asynchronous
//   sw_mins        in   [6:0] live minutes from the counter
//   sw_secs        in   [5:0] live seconds from the counter
//   sw_decs        in   [6:0] live hundredths from the counter
//   sw_overflow    in   counter overflow level
//   start_stop     out  counter run enable (RUN, LAP)
//   hold           out  counter freeze (PAUSED, OVERFLOW)
//   sw_reset_n     out  active-low counter clear (CLEARING)
//   disp_mins      out  [6:0] displayed minutes
//   disp_secs      out  [5:0] displayed seconds
//   disp_decs      out  [6:0] displayed hundredths
//   lap_active     out  display shows the frozen lap value (LAP)
//   overflow_flag  out  overflow latched (OVERFLOW)
//
// Parameters:
//   DEBOUNCE_TICKS  consecutive equal synchronised samples before a debounced
//                   level changes, 1..15
//   CLEAR_PULSE     cycles sw_reset_n is held low in CLEARING, 1..7
// -----------------------------------------------------------------------------
module stopwatch_control_fsm #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CLEAR_PULSE    = 2
) (
  input  logic       CLK_100Hz,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [6:0] sw_mins,
  input  logic [5:0] sw_secs,
  input  logic [6:0] sw_decs,
  input  logic       sw_overflow,
  output logic       start_stop,
  output logic       hold,
  output logic       sw_reset_n,
  output logic [6:0] disp_mins,
  output logic [5:0] disp_secs,
  output logic [6:0] disp_decs,
  output logic       lap_active,
  output logic       overflow_flag
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_LAP      = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_CLEARING = 3'd4,
    ST_OVERFLOW = 3'd5
  } state_t;

  // Button vector index: 0 = start/stop, 1 = lap, 2 = clear.
  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  // The count that would reach DEBOUNCE_TICKS / CLEAR_PULSE on this edge.
  localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE_TICKS - 1);
  localparam logic [2:0] CLR_LAST = 3'(CLEAR_PULSE - 1);

  logic [2:0] raw_s;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] db_r;
  logic [2:0] db_d_r;
  logic [3:0] db_cnt_r [3];
  logic [2:0] press_s;

  state_t     state_r;
  state_t     next_state_s;
  logic       lap_load_s;
  logic [2:0] clr_cnt_r;

  logic       start_stop_r;
  logic       hold_r;
  logic       sw_reset_n_r;
  logic       lap_active_r;
  logic       overflow_flag_r;
  logic [6:0] lap_mins_r;
  logic [5:0] lap_secs_r;
  logic [6:0] lap_decs_r;

  assign raw_s   = {btn_clear, btn_lap, btn_start_stop};
  // One-cycle pulse on the debounced rising edge; releases are silent.
  assign press_s = db_r & ~db_d_r;

  // Synchronise and debounce the three buttons.
  always_ff @(posedge CLK_100Hz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      db_r    <= 3'b000;
      db_d_r  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= 4'd0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_r[i]     <= ~db_r[i];
            db_cnt_r[i] <= 4'd0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 4'd1;
          end
        end else begin
          db_cnt_r[i] <= 4'd0;
        end
      end
    end
  end

  // Next-state decode; the first matching legal event wins, others drop.
  always_comb begin
    next_state_s = state_r;
    lap_load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s[BTN_CLR]) begin
          next_state_s = ST_CLEARING;
        end else if (press_s[BTN_SS]) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sw_overflow) begin
          next_state_s = ST_OVERFLOW;
        end else if (press_s[BTN_SS]) begin
          next_state_s = ST_PAUSED;
        end else if (press_s[BTN_LAP]) begin
          next_state_s = ST_LAP;
          lap_load_s   = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (sw_overflow) begin
          next_state_s = ST_OVERFLOW;
        end else if (press_s[BTN_CLR]) begin
          next_state_s = ST_RUN;
        end else if (press_s[BTN_SS]) begin
          next_state_s = ST_PAUSED;
        end else if (press_s[BTN_LAP]) begin
          next_state_s = ST_LAP;
          lap_load_s   = 1'b1;
        end else begin
          next_state_s = ST_LAP;
        end
      end
      ST_PAUSED: begin
        if (press_s[BTN_CLR]) begin
          next_state_s = ST_CLEARING;
        end else if (press_s[BTN_SS]) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_PAUSED;
        end
      end
      ST_CLEARING: begin
        if (clr_cnt_r == CLR_LAST) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_CLEARING;
        end
      end
      ST_OVERFLOW: begin
        if (press_s[BTN_CLR]) begin
          next_state_s = ST_CLEARING;
        end else begin
          next_state_s = ST_OVERFLOW;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register, clear-pulse counter, registered Moore outputs, lap capture.
  always_ff @(posedge CLK_100Hz or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      clr_cnt_r       <= 3'd0;
      start_stop_r    <= 1'b0;
      hold_r          <= 1'b0;
      sw_reset_n_r    <= 1'b1;
      lap_active_r    <= 1'b0;
      overflow_flag_r <= 1'b0;
      lap_mins_r      <= 7'd0;
      lap_secs_r      <= 6'd0;
      lap_decs_r      <= 7'd0;
    end else begin
      state_r <= next_state_s;
      // Counts cycles already spent in CLEARING; zero on entry.
      if (state_r == ST_CLEARING) begin
        clr_cnt_r <= clr_cnt_r + 3'd1;
      end else begin
        clr_cnt_r <= 3'd0;
      end
      // Outputs are decoded from the next state so they align with state_r.
      start_stop_r    <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
      hold_r          <= (next_state_s == ST_PAUSED) || (next_state_s == ST_OVERFLOW);
      sw_reset_n_r    <= (next_state_s != ST_CLEARING);
      lap_active_r    <= (next_state_s == ST_LAP);
      overflow_flag_r <= (next_state_s == ST_OVERFLOW);
      if (lap_load_s) begin
        lap_mins_r <= sw_mins;
        lap_secs_r <= sw_secs;
        lap_decs_r <= sw_decs;
      end
    end
  end

  assign start_stop    = start_stop_r;
  assign hold          = hold_r;
  assign sw_reset_n    = sw_reset_n_r;
  assign lap_active    = lap_active_r;
  assign overflow_flag = overflow_flag_r;

  assign disp_mins = lap_active_r ? lap_mins_r : sw_mins;
  assign disp_secs = lap_active_r ? lap_secs_r : sw_secs;
  assign disp_decs = lap_active_r ? lap_decs_r : sw_decs;

endmodule

// File: doc/stopwatch_control_fsm.md
Name: stopwatch_control_fsm

Overview:
Front-panel controller for the 100 Hz stopwatch counter. It synchronises and debounces three raw push buttons (start/stop, lap, clear) and sequences the counter's start_stop, hold and reset inputs through a Moore state machine. It also captures lap times and selects live or frozen time for the display path. It sits between the board buttons and the stopwatch counter, and its display outputs feed the seven-segment formatter.

Parameters:
DEBOUNCE_TICKS, 3, consecutive equal synchronised samples needed before a debounced level changes (3 = 30 ms at 100 Hz); legal range 1..15
CLEAR_PULSE, 2, number of cycles sw_reset_n is held low in CLEARING; legal range 1..7

Ports:
CLK_100Hz  in  1  system clock, 100 Hz
reset_n  in  1  reset
btn_start_stop  in  1  raw button, active high, asynchronous
btn_lap  in  1  raw button, active high, asynchronous
btn_clear  in  1  raw button, active high, asynchronous
sw_mins  in  7  live minutes from the counter
sw_secs  in  6  live seconds from the counter
sw_decs  in  7  live hundredths from the counter
sw_overflow  in  1  counter overflow level
start_stop  out  1  counter run enable
hold  out  1  counter freeze
sw_reset_n  out  1  active-low clear to the counter
disp_mins  out  7  displayed minutes
disp_secs  out  6  displayed seconds
disp_decs  out  7  displayed hundredths
lap_active  out  1  display is showing the frozen lap value
overflow_flag  out  1  overflow latched

Behaviour:
- Clock and reset: single clock CLK_100Hz; reset_n is asynchronous, active-low.
- While reset_n=0: state=IDLE; start_stop=0, hold=0, sw_reset_n=1, lap_active=0, overflow_flag=0; lap registers=0; debounced levels=0; debounce counters=0; synchroniser flops=0.
- Input path, per button: 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synchronised sample differs from the debounced level and clears when they match.
  - When the count reaches DEBOUNCE_TICKS, the debounced level toggles and the counter clears.
  - A press pulse is one cycle wide, on the debounced 0->1 edge. Releases generate nothing.
- Press latency: a raw press stable from clock edge k gives its pulse in cycle k+2+DEBOUNCE_TICKS (k+5 at default).
- Glitches shorter than DEBOUNCE_TICKS synchronised samples produce no pulse.
- A button held through reset deassertion yields exactly one pulse after debounce.
- Simultaneous pulses in one cycle: clear > start_stop > lap. Only the highest-priority legal event acts; the rest are dropped.
- sw_overflow=1 in RUN or LAP overrides all presses that cycle.
- FSM states and transitions (each transition takes effect at the next edge):
  - IDLE: start_stop press -> RUN; clear press -> CLEARING; lap press ignored.
  - RUN: sw_overflow -> OVERFLOW; start_stop press -> PAUSED; lap press -> LAP and capture sw_* into the lap registers on the same edge; clear press ignored.
  - LAP (counter keeps running): sw_overflow -> OVERFLOW; clear press -> RUN (releases the lap view); start_stop press -> PAUSED; lap press -> LAP with a recapture.
  - PAUSED: start_stop press -> RUN; clear press -> CLEARING; lap press ignored.
  - CLEARING: stays for exactly CLEAR_PULSE cycles, then -> IDLE; all presses ignored.
  - OVERFLOW: only clear press -> CLEARING.
- Moore outputs, registered and decoded from the state register:
  - start_stop=1 in RUN and LAP.
  - hold=1 in PAUSED and OVERFLOW.
  - sw_reset_n=0 in CLEARING only.
  - lap_active=1 in LAP.
  - overflow_flag=1 in OVERFLOW.
- Display mux (combinational): disp_* = lap registers when lap_active=1, otherwise sw_* passed through unchanged. Widths match the inputs exactly; no arithmetic.
- sw_overflow in IDLE, PAUSED or CLEARING is ignored; the counter's own reset clears it.
- Asserting reset_n mid-operation, in any state, forces the reset values immediately (asynchronously), abandons any partial debounce, and leaves the lap registers at 0.

Test Plan:
- Reset, then btn_start_stop high for 10 cycles -> press pulse in cycle k+5; state RUN; start_stop=1, hold=0; disp tracks sw_*.
- RUN with sw = 01:23.45, debounced lap press -> lap_active=1; disp holds 001:23.45 while sw_* advances; second lap at 02:00.10 -> disp = 002:00.10; clear press -> lap_active=0, disp live.
- RUN -> start_stop press -> PAUSED (start_stop=0, hold=1); clear press -> sw_reset_n low for exactly 2 cycles -> IDLE, hold=0.
- btn_start_stop and btn_clear both rising in the same cycle while PAUSED -> CLEARING taken; no RUN entry. A 2-cycle btn_lap glitch -> no pulse.
- RUN with sw_overflow=1 and start_stop press in the same cycle -> OVERFLOW (overflow_flag=1, start_stop=0, hold=1); start_stop and lap presses ignored; clear press -> CLEARING -> IDLE.
- reset_n driven low mid-debounce in LAP with btn_start_stop held -> all outputs at reset values within the cycle. After release with the button still held -> exactly one pulse at release+5 -> RUN.
